counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 48 ++++
 tb/tb_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/counter.sv
// counter: WIDTH-bit loadable up-counter.
// Next-value priority is clear, then load, then increment, otherwise hold.
// The increment wraps modulo 2^WIDTH. The asynchronous active-high reset
// forces the count to zero at once. The output comes straight from the
// count register, so it has no combinational path from any input.
module counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_sysclk,
   input  logic             i_sysrst,
   input  logic             i_cnt_en,
   input  logic             i_ld,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_ld_data,
   output logic [WIDTH-1:0] o_cnt_data
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next-count selection by fixed priority: clear > load > increment > hold.
   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_ld) begin
         count_d = i_ld_data;
      end else if (i_cnt_en) begin
         count_d = count_q + ONE;   // natural wrap: all-ones + 1 -> 0
      end
   end

   // Count register with asynchronous active-high reset.
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      // NOTE: non-blocking assignments for registered state avoid simulation races.
      if (i_sysrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_cnt_data = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for counter.
// The stimulus process drives the inputs on falling edges. For each cycle it
// works out the expected count from the rules with plain arithmetic and
// queues that value. A separate monitor removes one expected value after
// each rising edge and compares it with the output.
module tb_counter;

   localparam int          W   = 16;
   localparam int unsigned MOD = 32'd1 << W;

   logic         clk;
   logic         rst;
   logic         cnt_en;
   logic         ld;
   logic         clr;
   logic [W-1:0] ld_data;
   logic [W-1:0] cnt_data;

   int unsigned  model;
   logic [W-1:0] exp_q[$];
   int           n_tests;
   int           n_fail;

   counter #(.WIDTH(W)) dut (
      .i_sysclk  (clk),
      .i_sysrst  (rst),
      .i_cnt_en  (cnt_en),
      .i_ld      (ld),
      .i_clr     (clr),
      .i_ld_data (ld_data),
      .o_cnt_data(cnt_data)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the count expected after the next edge.
   task automatic step(input logic r, input logic c, input logic l, input logic e,
                       input logic [W-1:0] d);
      @(negedge clk);
      rst = r; clr = c; ld = l; cnt_en = e; ld_data = d;
      if (r)      model = 0;
      else if (c) model = 0;
      else if (l) model = int'(d);
      else if (e) model = (model + 1) % MOD;
      exp_q.push_back(W'(model));
   endtask

   task automatic load(input logic [W-1:0] d);
      step(1'b0, 1'b0, 1'b1, 1'b0, d);
   endtask

   // Monitor: one output value per rising edge, compared against the scoreboard.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cnt", cnt_data, e);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model   = 0;
      rst = 1'b1; clr = 1'b0; ld = 1'b0; cnt_en = 1'b0; ld_data = '0;

      // Reset held 100 ns with all controls low.
      #1 check("reset_at_start", cnt_data, '0);
      repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      repeat (3)  step(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Load 0x000F, then hold. A data change while ld is low has no effect.
      load(16'h000F);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h000F);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);

      // Load 0xF569, then a one-clock clear.
      load(16'hF569);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Load 0xFFF0, then count through the wrap to 0x0001.
      load(16'hFFF0);
      repeat (17) step(1'b0, 1'b0, 1'b0, 1'b1, '0);

      // Priority: clear beats load, and load beats increment.
      load(16'h1234);
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);
      load(16'h1234);
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555);

      // Asynchronous reset between edges while counting.
      load(16'h7000);
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check("async_reset_mid_cycle", cnt_data, '0);
      model = 0;
      step(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, '0);

      // Randomised traffic, including occasional reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) != 0),
              W'($urandom));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Drain the scoreboard within a bounded number of cycles.
      repeat (4) @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
